// File: rtl/eros_obi_addr_demux.sv
// OBI address-decoding demultiplexer: routes one master's request stream to the
// matching crossbar slave port, keeps responses in order and answers unmapped addresses.

package eros_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam int unsigned SYSTEM_XBAR_NSLAVE = 5;

  // Element 4 is listed first; end_addr is exclusive.
  localparam addr_map_rule_t [4:0] XBAR_ADDR_RULES = '{
    '{idx: 32'd4, start_addr: 32'h1902_8000, end_addr: 32'h1903_0000},  // RAM1
    '{idx: 32'd3, start_addr: 32'h1902_0000, end_addr: 32'h1902_8000},  // RAM0
    '{idx: 32'd1, start_addr: 32'h1901_0000, end_addr: 32'h1902_0000},  // peripheral
    '{idx: 32'd2, start_addr: 32'h1900_2000, end_addr: 32'h1901_0000},  // external peripheral
    '{idx: 32'd0, start_addr: 32'h1900_0000, end_addr: 32'h1900_2000}   // boot ROM
  };

endpackage

module eros_obi_addr_demux #(
  parameter int unsigned                             NSLAVE          = eros_pkg::SYSTEM_XBAR_NSLAVE,
  parameter int unsigned                             NRULES          = 5,
  parameter eros_pkg::addr_map_rule_t [NRULES-1:0]   ADDR_RULES      = eros_pkg::XBAR_ADDR_RULES,
  parameter int unsigned                             MAX_OUTSTANDING = 4,
  parameter logic [31:0]                             ERR_RDATA       = 32'hBADACCE5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic [31:0]                  addr_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [31:0]                  wdata_i,
  output logic                         rvalid_o,
  output logic [31:0]                  rdata_o,
  output logic                         err_o,
  output logic [NSLAVE-1:0]            slv_req_o,
  input  logic [NSLAVE-1:0]            slv_gnt_i,
  output logic [31:0]                  slv_addr_o,
  output logic                         slv_we_o,
  output logic [3:0]                   slv_be_o,
  output logic [31:0]                  slv_wdata_o,
  input  logic [NSLAVE-1:0]            slv_rvalid_i,
  input  logic [NSLAVE-1:0][31:0]      slv_rdata_i,
  output logic                         spurious_o
);

  localparam int unsigned SW = $clog2(NSLAVE + 1);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SW-1:0] SEL_ERR = SW'(NSLAVE);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_last_sel;
  logic              r_err_pend;
  logic              r_spurious;

  logic [SW-1:0]     w_target;
  logic              w_tgt_is_err;
  logic              w_allow;
  logic              w_tgt_gnt;
  logic              w_last_is_err;
  logic              w_sel_rvalid;
  logic [31:0]       w_sel_rdata;
  logic              w_spurious;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  // Descending scan makes the lowest-numbered matching rule win.
  always_comb begin
    w_target = SEL_ERR;
    for (int i = int'(NRULES) - 1; i >= 0; i--) begin
      if (addr_i >= ADDR_RULES[i].start_addr && addr_i < ADDR_RULES[i].end_addr) begin
        w_target = SW'(ADDR_RULES[i].idx);
      end
    end
  end

  assign w_tgt_is_err  = (w_target == SEL_ERR);
  assign w_last_is_err = (r_last_sel == SEL_ERR);

  // Responses only come back in order if all outstanding requests share one target.
  assign w_allow = rst_ni && req_i && (r_cnt < CNT_MAX) &&
                   ((r_cnt == '0) || (w_target == r_last_sel));

  always_comb begin
    slv_req_o    = '0;
    w_tgt_gnt    = 1'b0;
    w_sel_rvalid = 1'b0;
    w_sel_rdata  = '0;
    w_spurious   = 1'b0;
    for (int s = 0; s < int'(NSLAVE); s++) begin
      if (w_target == SW'(s)) begin
        slv_req_o[s] = w_allow;
        w_tgt_gnt    = slv_gnt_i[s];
      end
      if (r_last_sel == SW'(s)) begin
        w_sel_rvalid = slv_rvalid_i[s];
        w_sel_rdata  = slv_rdata_i[s];
      end
      if (slv_rvalid_i[s] && ((r_cnt == '0) || (r_last_sel != SW'(s)))) begin
        w_spurious = 1'b1;
      end
    end
  end

  assign gnt_o = w_allow && (w_tgt_is_err || w_tgt_gnt);

  assign slv_addr_o  = addr_i;
  assign slv_we_o    = we_i;
  assign slv_be_o    = be_i;
  assign slv_wdata_o = wdata_i;

  assign rvalid_o   = w_last_is_err ? r_err_pend : ((r_cnt != '0) && w_sel_rvalid);
  assign err_o      = rvalid_o && w_last_is_err;
  assign rdata_o    = !rvalid_o ? 32'h0 : (w_last_is_err ? ERR_RDATA : w_sel_rdata);
  assign spurious_o = r_spurious;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_last_sel <= '0;
      r_err_pend <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      if (gnt_o) begin
        r_last_sel <= w_target;
      end
      if (gnt_o && !rvalid_o) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!gnt_o && rvalid_o) begin
        r_cnt <= r_cnt - CW'(1);
      end
      // A new ERR grant in the response cycle keeps the pending flag alive.
      if (gnt_o && w_tgt_is_err) begin
        r_err_pend <= 1'b1;
      end else if (rvalid_o && w_last_is_err) begin
        r_err_pend <= 1'b0;
      end
      if (w_spurious) begin
        r_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: doc/eros_obi_addr_demux.md
# eros_obi_addr_demux

OBI address-decoding demultiplexer placed directly upstream of the system crossbar slave ports: it takes one master's OBI request stream (one core instruction/data port or the external master), decodes the address against the system address map, and forwards each request to the matching slave port. It tracks outstanding transactions so responses return in order, and answers unmapped addresses with an internal error response.

## Interface
- NSLAVE, 5 (eros_pkg::SYSTEM_XBAR_NSLAVE): number of slave ports.
- NRULES, 5: number of address rules.
- ADDR_RULES, eros_pkg::XBAR_ADDR_RULES: addr_map_rule_t [NRULES-1:0]; idx field < NSLAVE.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered transactions; ≥1.
- ERR_RDATA, 32'hBADACCE5: rdata returned for unmapped accesses.
- clk_i  in  1  single clock; everything on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i, gnt_o, addr_i[31:0], we_i, be_i[3:0], wdata_i[31:0]: master request side (in/out/in/in/in/in).
- rvalid_o  out  1, rdata_o  out  32, err_o  out  1: master response side.
- slv_req_o  out  NSLAVE: one-hot request per slave.
- slv_gnt_i  in  NSLAVE.
- slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o  out  32/1/4/32: broadcast to all slaves, qualified by slv_req_o.
- slv_rvalid_i  in  NSLAVE; slv_rdata_i  in  NSLAVE×32.
- spurious_o  out  1: sticky flag, response seen from a slave with no outstanding transaction.

## Operation
- Decode (combinational): rule i matches when start_addr ≤ addr_i < end_addr; lowest-numbered matching rule wins; no match → target ERR (internal, encoded as NSLAVE).
- Registered state: cnt (0..MAX_OUTSTANDING), last_sel (target of outstanding transactions), err_pend (1 bit), spurious (1 bit).
- Issue allowed when req_i && cnt < MAX_OUTSTANDING && (cnt == 0 || target == last_sel). Not allowed → slv_req_o = 0, gnt_o = 0 (stall; master holds request).
- Allowed, mapped target s: slv_req_o[s] = 1, gnt_o = slv_gnt_i[s]; handshake when both high.
- Allowed, target ERR: gnt_o = 1 immediately (handshake), no slave request, err_pend set.
- On handshake: last_sel ← target; cnt increments.
- Response: if last_sel is a slave and cnt > 0: rvalid_o = slv_rvalid_i[last_sel], rdata_o = its rdata, err_o = 0. If last_sel = ERR: rvalid_o = err_pend, rdata_o = ERR_RDATA, err_o = 1; err_pend clears on that cycle unless a new ERR handshake occurs in the same cycle (then stays set).
- cnt: +1 on handshake, −1 on rvalid_o, unchanged when both occur in the same cycle.
- Any slv_rvalid_i[k] high while (cnt == 0 or k ≠ last_sel): ignored for the master, spurious set; cleared only by reset.
- When rvalid_o = 0, rdata_o = 0 and err_o = 0.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream): cnt = 0, last_sel = 0, err_pend = 0, spurious = 0; all outputs 0 (gnt_o, rvalid_o, err_o, slv_req_o, spurious_o, rdata_o). Reset mid-transaction drops all outstanding state.
- Request path is zero-latency combinational: req_i → slv_req_o, slv_gnt_i → gnt_o; no cycle added.
- Error response: rvalid_o exactly one cycle after the ERR grant. Back-to-back ERR requests yield one response per cycle.
- Target switch: the first request to a different target stalls until the cycle after the last outstanding rvalid_o (cnt registered at 0).
- Full: at cnt == MAX_OUTSTANDING the request stalls even if rvalid_o is high that cycle; issue resumes the next cycle.

## Test plan
- Read 0x19020000 (RAM0, idx 3), slave grants at once and answers rdata 0x12345678 two cycles later → slv_req_o = 5'b01000, gnt_o same cycle, rvalid_o with 0x12345678, err_o = 0, cnt back to 0.
- Four back-to-back reads to 0x19028000 (RAM1) with responses delayed → four grants, fifth request stalls (gnt_o = 0) until the first response, then is granted the following cycle.
- Read 0x19010000 (peripheral) outstanding, then request 0x19002000 (external peripheral) → second request stalls, slv_req_o = 0, until the peripheral rvalid, then slv_req_o = 5'b00100.
- Read 0x30000000 (unmapped) → gnt_o in the same cycle, next cycle rvalid_o = 1, err_o = 1, rdata_o = 0xBADACCE5; no slave request issued.
- Pulse slv_rvalid_i[4] with cnt = 0 → rvalid_o stays 0, spurious_o = 1 and holds; rst_ni low mid-transaction clears it and all counters asynchronously.
